// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S transmit (i2s_tx) and receive (I2S_Serf)
// ends of the link: default geometry constants, the sample type and the
// left/right pair type moved across the sample handshake.
// ---------------------------------------------------------------------------
package i2s_pkg;

   localparam int I2S_DATA_BITS = 24;   // sample width per channel
   localparam int I2S_SLOT_BITS = 32;   // sclk periods per channel slot
   localparam int I2S_SCLK_DIV  = 8;    // clk cycles per sclk half-period

   typedef logic [I2S_DATA_BITS-1:0] i2s_sample_t;

   typedef struct packed {
      i2s_sample_t left;
      i2s_sample_t right;
   } i2s_pair_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// ---------------------------------------------------------------------------
// i2s_clk_gen
// Bit-clock divider for the I2S link. A counter runs 0..SCLK_DIV-1 and the
// sclk register toggles at terminal count, giving an sclk period of
// 2*SCLK_DIV clk with 50% duty.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset (count=0, sclk=0)
//   I2S_sclk   out  registered serial bit clock
//   sclk_rise  out  1-clk strobe: sclk goes 0->1 on the coming clk edge
//   sclk_fall  out  1-clk strobe: sclk goes 1->0 on the coming clk edge
// ---------------------------------------------------------------------------
module i2s_clk_gen
   import i2s_pkg::*;
#(
   parameter int SCLK_DIV = I2S_SCLK_DIV
)(
   input  logic clk,
   input  logic rst,
   output logic I2S_sclk,
   output logic sclk_rise,
   output logic sclk_fall
);

   localparam int               CNT_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_DIV - 1);

   logic [CNT_W-1:0] div_cnt;
   logic             term_cnt;

   assign term_cnt = (div_cnt == CNT_LAST);

   // The strobes mark the clk cycle whose closing edge performs the toggle,
   // so logic clocked on the same edge updates together with sclk.
   assign sclk_rise = term_cnt & ~I2S_sclk;
   assign sclk_fall = term_cnt &  I2S_sclk;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt  <= '0;
         I2S_sclk <= 1'b0;
      end else if (term_cnt) begin
         div_cnt  <= '0;
         I2S_sclk <= ~I2S_sclk;
      end else begin
         div_cnt  <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx
// I2S (Philips format) master transmitter. Generates sclk/ws/data from clk
// and serializes left/right samples, MSB first, one bit after each ws edge.
// A one-deep holding register accepts pairs over a valid/ready handshake;
// at every frame start it is moved into the frame buffer that is shifted
// out. A frame start with no new pair raises underrun and repeats the last
// pair.
//
// Optional build macro:
//   I2S_TX_MUTE_ON_UNDERRUN_EN  - on underrun the frame buffer is cleared so
//                                 silence is sent instead of a repeated pair.
//
// Ports:
//   clk        in   system clock (only clock)
//   rst        in   synchronous, active-high reset
//   lft_in     in   left sample, two's complement
//   rght_in    in   right sample, two's complement
//   vld        in   sample pair valid
//   rdy        out  holding register empty (registered)
//   I2S_sclk   out  serial bit clock, period 2*SCLK_DIV clk
//   I2S_ws     out  word select, 0 = left, 1 = right
//   I2S_data   out  serial data, MSB first
//   frm_strt   out  1-clk pulse at each frame (left slot) start
//   underrun   out  1-clk pulse when a frame starts without a new pair
// ---------------------------------------------------------------------------
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int SCLK_DIV  = I2S_SCLK_DIV,
   parameter int SLOT_BITS = I2S_SLOT_BITS,
   parameter int DATA_BITS = I2S_DATA_BITS
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] lft_in,
   input  logic [DATA_BITS-1:0] rght_in,
   input  logic                 vld,
   output logic                 rdy,
   output logic                 I2S_sclk,
   output logic                 I2S_ws,
   output logic                 I2S_data,
   output logic                 frm_strt,
   output logic                 underrun
);

   localparam int              BC_W     = $clog2(2 * SLOT_BITS);
   localparam logic [BC_W-1:0] BC_LAST  = BC_W'(2 * SLOT_BITS - 1);
   localparam logic [BC_W-1:0] SLOT_LEN = BC_W'(SLOT_BITS);
   localparam logic [BC_W-1:0] DATA_LEN = BC_W'(DATA_BITS);

   // Bit clock
   logic sclk_fall;
   logic sclk_rise_unused;   // the transmitter only acts on falling edges

   i2s_clk_gen #(
      .SCLK_DIV (SCLK_DIV)
   ) u_clk_gen (
      .clk       (clk),
      .rst       (rst),
      .I2S_sclk  (I2S_sclk),
      .sclk_rise (sclk_rise_unused),
      .sclk_fall (sclk_fall)
   );

   // Slot position and next serial bit
   logic [BC_W-1:0]      bit_cnt;
   logic [BC_W-1:0]      bit_cnt_nxt;
   logic [BC_W-1:0]      slot_pos;
   logic [BC_W-1:0]      shift_amt;
   logic                 ws_nxt;
   logic                 data_nxt;
   logic [DATA_BITS-1:0] chan_word;
   logic [DATA_BITS-1:0] chan_shift;
   logic [DATA_BITS-1:0] fb_lft;
   logic [DATA_BITS-1:0] fb_rght;

   always_comb begin
      bit_cnt_nxt = (bit_cnt == BC_LAST) ? '0 : bit_cnt + 1'b1;
      ws_nxt      = (bit_cnt_nxt >= SLOT_LEN);
      slot_pos    = ws_nxt ? (bit_cnt_nxt - SLOT_LEN) : bit_cnt_nxt;
      chan_word   = ws_nxt ? fb_rght : fb_lft;
      // Position k in the slot carries bit [DATA_BITS-k]; shifting left by
      // k-1 brings that bit to the MSB. Position 0 is the Philips one-bit
      // delay after the ws edge and positions past DATA_BITS are padding.
      shift_amt   = slot_pos - 1'b1;
      chan_shift  = chan_word << shift_amt;
      data_nxt    = ((slot_pos != '0) && (slot_pos <= DATA_LEN)) ?
                    chan_shift[DATA_BITS-1] : 1'b0;
   end

   // Frame load happens on the fall that wraps bit_cnt to 0. During that
   // cycle slot_pos is 0, so the bit emitted never reads the buffer being
   // replaced.
   logic frame_load;
   assign frame_load = sclk_fall && (bit_cnt == BC_LAST);

   // Holding register
   logic                 hold_full;
   logic                 accept;
   logic [DATA_BITS-1:0] hold_lft;
   logic [DATA_BITS-1:0] hold_rght;

   assign rdy    = ~hold_full;
   assign accept = vld & ~hold_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= BC_LAST;
         I2S_ws    <= 1'b0;
         I2S_data  <= 1'b0;
         frm_strt  <= 1'b0;
         underrun  <= 1'b0;
         hold_full <= 1'b0;
         fb_lft    <= '0;
         fb_rght   <= '0;
      end else begin
         frm_strt <= 1'b0;
         underrun <= 1'b0;

         // Serial outputs only move on sclk falls so they are stable
         // across every rising edge seen by the receiver.
         if (sclk_fall) begin
            bit_cnt  <= bit_cnt_nxt;
            I2S_ws   <= ws_nxt;
            I2S_data <= data_nxt;
         end

         if (frame_load) begin
            frm_strt <= 1'b1;
            if (hold_full) begin
               fb_lft    <= hold_lft;
               fb_rght   <= hold_rght;
               hold_full <= 1'b0;
            end else begin
               underrun <= 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
               fb_lft   <= '0;
               fb_rght  <= '0;
`endif
            end
         end

         // accept implies the holding register was empty, so it never
         // collides with the load branch above; a pair arriving on the
         // load cycle simply waits for the following frame.
         if (accept) begin
            hold_full <= 1'b1;
         end
      end
   end

   // Holding data needs no reset: it is only read while hold_full is set.
   always_ff @(posedge clk) begin
      if (accept) begin
         hold_lft  <= lft_in;
         hold_rght <= rght_in;
      end
   end

endmodule

// File: tb/tb_i2s_tx.sv
`timescale 1ns/1ps
module tb_i2s_tx;
   import i2s_pkg::*;

   localparam int SCLK_DIV   = 8;
   localparam int SLOT_BITS  = 32;
   localparam int DATA_BITS  = 24;
   localparam int FRAME_CLK  = 4 * SLOT_BITS * SCLK_DIV;   // 1024
   localparam int FIRST_LOAD = 2 * SCLK_DIV;               // 16

   logic                 clk = 1'b0;
   logic                 rst;
   logic [DATA_BITS-1:0] lft_in;
   logic [DATA_BITS-1:0] rght_in;
   logic                 vld;
   logic                 rdy;
   logic                 I2S_sclk;
   logic                 I2S_ws;
   logic                 I2S_data;
   logic                 frm_strt;
   logic                 underrun;

   always #5 clk = ~clk;

   i2s_tx #(
      .SCLK_DIV  (SCLK_DIV),
      .SLOT_BITS (SLOT_BITS),
      .DATA_BITS (DATA_BITS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .lft_in   (lft_in),
      .rght_in  (rght_in),
      .vld      (vld),
      .rdy      (rdy),
      .I2S_sclk (I2S_sclk),
      .I2S_ws   (I2S_ws),
      .I2S_data (I2S_data),
      .frm_strt (frm_strt),
      .underrun (underrun)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Transaction-level model state
   i2s_pair_t pend[$];      // accepted pairs not yet started as a frame
   i2s_pair_t exp_q[$];     // frames expected on the wire, in order
   i2s_pair_t last_pair;
   i2s_pair_t acc_pair;
   bit        acc_flag;
   int        cyc;
   int        last_toggle;
   int        frames_rx = 0;
   logic      sclk_prev;

   // Receiver state
   bit                   armed;
   bit                   rx_started;
   bit                   pad_bad;
   logic                 rx_ws;
   int                   rx_cnt;
   logic [DATA_BITS-1:0] rx_word;
   logic [DATA_BITS-1:0] rx_left;

   // Monitor: samples at negedge, i.e. the state left by the preceding posedge
   initial begin : monitor
      i2s_pair_t cur;
      i2s_pair_t got;
      bit        exp_fs;
      forever begin
         @(negedge clk);
         if (rst) begin
            check("reset_outputs",
                  64'({I2S_sclk, I2S_ws, I2S_data, frm_strt, underrun, rdy}),
                  64'(6'b000001));
            cyc = 0; last_toggle = 0; sclk_prev = 1'b0;
            pend.delete(); exp_q.delete();
            last_pair = '0; armed = 0; rx_started = 0;
         end else begin
            cyc++;
            if (I2S_sclk !== sclk_prev) begin
               check("sclk_half_period", 64'(cyc - last_toggle), 64'(SCLK_DIV));
               last_toggle = cyc;
            end
            exp_fs = (cyc >= FIRST_LOAD) && (((cyc - FIRST_LOAD) % FRAME_CLK) == 0);
            if (frm_strt || exp_fs)
               check("frm_strt_timing", 64'(frm_strt), 64'(exp_fs));
            if (frm_strt || underrun)
               check("underrun", 64'(underrun), 64'(frm_strt && (pend.size() == 0)));
            if (frm_strt) begin
               if (pend.size() > 0) cur = pend.pop_front();
               else begin
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
                  cur = '0;
`else
                  cur = last_pair;
`endif
               end
               last_pair = cur;
               exp_q.push_back(cur);
               if (!armed) begin
                  armed = 1; rx_ws = 1'b1; rx_started = 0;
               end
            end
            if (acc_flag) begin
               pend.push_back(acc_pair);
               acc_flag = 0;
            end
            check("rdy", 64'(rdy), 64'(pend.size() == 0));

            // I2S receiver: sample on sclk rising edges
            if (armed && I2S_sclk && !sclk_prev) begin
               if (I2S_ws !== rx_ws) begin
                  if (rx_started) check("slot_length", 64'(rx_cnt), 64'(SLOT_BITS));
                  rx_ws = I2S_ws; rx_cnt = 0; rx_started = 1; rx_word = '0; pad_bad = 0;
               end
               if (rx_cnt >= 1 && rx_cnt <= DATA_BITS) rx_word = {rx_word[DATA_BITS-2:0], I2S_data};
               else if (I2S_data !== 1'b0) pad_bad = 1;
               rx_cnt++;
               if (rx_started && rx_cnt == SLOT_BITS) begin
                  check("pad_bits_zero", 64'(pad_bad), 64'(0));
                  if (!rx_ws) rx_left = rx_word;
                  else if (exp_q.size() == 0) begin
                     check("frame_expected", 64'(exp_q.size()), 64'(1));
                  end else begin
                     got.left  = rx_left;
                     got.right = rx_word;
                     cur = exp_q.pop_front();
                     check("frame_data", 64'(got), 64'(cur));
                     frames_rx++;
                  end
               end
            end
            sclk_prev = I2S_sclk;
         end
      end
   end

   // Stimulus: drives #1 after negedge; records what the next posedge accepts
   task automatic drive(input logic v, input logic [DATA_BITS-1:0] l,
                        input logic [DATA_BITS-1:0] r, input logic rs);
      @(negedge clk);
      #1;
      rst = rs; vld = v; lft_in = l; rght_in = r;
      if (v && rdy && !rs) begin
         acc_flag = 1;
         acc_pair.left  = l;
         acc_pair.right = r;
      end
   endtask

   initial begin : stim
      logic [DATA_BITS-1:0] a;
      logic [DATA_BITS-1:0] b;
      logic                 v;
      int                   ld;
      int                   ld2;
      int                   target;
      int                   mode;
      bit                   got_acc;
      rst = 1'b1; vld = 1'b0; lft_in = '0; rght_in = '0; acc_flag = 0;
      repeat (4) drive(1'b0, '0, '0, 1'b1);

      // First pair, vld held until accepted
      got_acc = 0;
      for (int i = 0; i < 50 && !got_acc; i++) begin
         drive(1'b1, 24'hA5A5A5, 24'h3C3C3C, 1'b0);
         got_acc = acc_flag;
      end
      check("first_pair_accepted", 64'(got_acc), 64'(1));

      // Starve: underrun frames follow; then vld exactly in a load cycle
      ld = FIRST_LOAD + 3 * FRAME_CLK;
      while (cyc < ld - 2) drive(1'b0, '0, '0, 1'b0);
      drive(1'b1, 24'h800001, 24'h7FFFFF, 1'b0);
      check("load_cycle_accept", 64'(acc_flag), 64'(1));
      drive(1'b0, '0, '0, 1'b0);

      // Randomized traffic with varying arrival rates
      mode = 0;
      for (int i = 0; cyc < ld + 21 * FRAME_CLK; i++) begin
         if (i % 2048 == 0) mode = $urandom_range(0, 2);
         a = DATA_BITS'($urandom);
         b = DATA_BITS'($urandom);
         case (mode)
            0:       v = ($urandom_range(0, 1) == 1);
            1:       v = ($urandom_range(0, 1999) == 0);
            default: v = 1'b0;
         endcase
         drive(v, a, b, 1'b0);
      end

      // Reset in the middle of a right slot (bit_cnt = 40) with a pair pending
      ld2    = FIRST_LOAD + FRAME_CLK * (((cyc - FIRST_LOAD) / FRAME_CLK) + 1);
      target = ld2 + 40 * 2 * SCLK_DIV;
      while (cyc < target - 1) drive(1'b1, DATA_BITS'($urandom), DATA_BITS'($urandom), 1'b0);
      repeat (3) drive(1'b0, '0, '0, 1'b1);

      // After reset: starve (buffer is zero), then random traffic
      while (cyc < FIRST_LOAD + 2 * FRAME_CLK + FRAME_CLK / 2) drive(1'b0, '0, '0, 1'b0);
      while (cyc < FIRST_LOAD + 7 * FRAME_CLK)
         drive($urandom_range(0, 3) == 0, DATA_BITS'($urandom), DATA_BITS'($urandom), 1'b0);

      check("frames_received", 64'(frames_rx >= 30), 64'(1));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish by 1000000ns");
      $fatal(1, "simulation timed out");
   end

endmodule
